// File: rtl/dsp_seq_pkg.sv
// Shared state encoding, widths and DSP opmode values for the MAC sequencer.
// Opmodes are restricted to multiply / multiply-accumulate / hold / clear.
package dsp_seq_pkg;

  localparam int OP_W  = 18;
  localparam int P_W   = 48;
  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;
  localparam logic [7:0] OPM_HOLD  = 8'h08;
  localparam logic [7:0] OPM_ZERO  = 8'h00;

  // Hold keeps the partial sum once one product has entered P; before that P is cleared.
  function automatic logic [7:0] opm_select(input logic i_accept, input logic i_seen);
    if (i_accept) begin
      return i_seen ? OPM_ACC : OPM_FIRST;
    end
    return i_seen ? OPM_HOLD : OPM_ZERO;
  endfunction

endpackage

// File: rtl/dsp_opmode_skew.sv
// DEPTH-cycle opmode delay line matching the operand register stages inside the DSP.
// Fixed latency DEPTH cycles, no backpressure; resets to OPM_ZERO.
module dsp_opmode_skew
  import dsp_seq_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_opm,
  output logic [7:0] o_opm
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_opm = i_opm;
    end else begin : g_line
      logic [7:0] r_line [DEPTH];

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_line[i] <= OPM_ZERO;
          end
        end else begin
          r_line[0] <= i_opm;
          for (int i = 1; i < DEPTH; i++) begin
            r_line[i] <= r_line[i-1];
          end
        end
      end

      assign o_opm = r_line[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Feeds len operand pairs into a pipelined DSP MAC and returns the dot product, PIPE_LAT+1 cycles after the last beat.
// in_ready is high only in LOAD; res_valid/res_data hold in DONE until res_ready.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int PIPE_LAT = 4,
  parameter int OPM_SKEW = 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  output logic [OP_W-1:0]  dsp_A,
  output logic [OP_W-1:0]  dsp_B,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_CE,
  output logic             dsp_RST,
  input  logic [P_W-1:0]   dsp_P,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [P_W-1:0]   res_data
);

  localparam logic [LEN_W-1:0] LAT_LAST = LEN_W'(PIPE_LAT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic             r_seen;
  logic [OP_W-1:0]  r_a;
  logic [OP_W-1:0]  r_b;
  logic [P_W-1:0]   r_res;
  logic [7:0]       r_opm;
  logic [7:0]       w_opm_nxt;
  logic             r_dsp_rst;
  logic             w_accept;
  logic             w_last_beat;
  logic             w_drain_end;

  assign w_accept    = in_valid && (r_state == LOAD);
  assign w_last_beat = w_accept && (r_cnt == r_len - LEN_W'(1));
  // DRAIN counts from the cycle the last operand sits on dsp_A until dsp_P carries its sum.
  assign w_drain_end = (r_state == DRAIN) && (r_cnt == LAT_LAST);

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (w_last_beat) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drain_end) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    w_opm_nxt = OPM_ZERO;
    case (r_state)
      IDLE: busy = 1'b0;
      LOAD: begin
        in_ready  = 1'b1;
        w_opm_nxt = opm_select(w_accept, r_seen);
      end
      DRAIN:   w_opm_nxt = OPM_HOLD;
      DONE:    res_valid = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      r_len     <= '0;
      r_cnt     <= '0;
      r_seen    <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_opm     <= OPM_ZERO;
      r_dsp_rst <= 1'b1;
    end else begin
      r_dsp_rst <= 1'b0;
      r_opm     <= w_opm_nxt;
      if (w_accept) begin
        r_a    <= in_a;
        r_b    <= in_b;
        r_seen <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_seen <= 1'b0;
          if (start) begin
            r_len <= len;
            if (len == '0) begin
              r_res <= '0;
            end
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_cnt <= w_last_beat ? '0 : r_cnt + LEN_W'(1);
          end
        end
        DRAIN: begin
          r_cnt <= r_cnt + LEN_W'(1);
          if (w_drain_end) begin
            r_res <= dsp_P;
          end
        end
        default: ;
      endcase
    end
  end

  // r_opm lines up with dsp_A; the skew line covers the DSP's own opmode register.
  dsp_opmode_skew #(
    .DEPTH (OPM_SKEW)
  ) u_opm_skew (
    .i_clk (clk),
    .i_rst (RST),
    .i_opm (r_opm),
    .o_opm (dsp_opmode)
  );

  assign dsp_A    = r_a;
  assign dsp_B    = r_b;
  assign dsp_CE   = ~RST;
  assign dsp_RST  = r_dsp_rst;
  assign res_data = r_res;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural model of the registered DSP slice on dsp_P.
module tb_dsp_mac_sequencer;

  localparam int PIPE_LAT = 4;
  localparam int OPM_SKEW = 2;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic [17:0] dsp_A;
  logic [17:0] dsp_B;
  logic [7:0]  dsp_opmode;
  logic        dsp_CE;
  logic        dsp_RST;
  logic [47:0] dsp_P;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(
    .PIPE_LAT (PIPE_LAT),
    .OPM_SKEW (OPM_SKEW)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .dsp_A      (dsp_A),
    .dsp_B      (dsp_B),
    .dsp_opmode (dsp_opmode),
    .dsp_CE     (dsp_CE),
    .dsp_RST    (dsp_RST),
    .dsp_P      (dsp_P),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data)
  );

  // DSP slice: A0/A1, B0/B1, M, OPMODE and P registers, synchronous reset over CE.
  logic signed [17:0] m_a0, m_a1, m_b0, m_b1;
  logic signed [47:0] m_m;
  logic [7:0]         m_opm;
  logic [47:0]        m_p;

  always @(posedge clk) begin
    if (dsp_RST) begin
      m_a0 <= '0; m_a1 <= '0; m_b0 <= '0; m_b1 <= '0;
      m_m <= '0; m_opm <= '0; m_p <= '0;
    end else if (dsp_CE) begin
      m_a0  <= dsp_A;
      m_a1  <= m_a0;
      m_b0  <= dsp_B;
      m_b1  <= m_b0;
      m_m   <= 48'(m_a1) * 48'(m_b1);
      m_opm <= dsp_opmode;
      case (m_opm)
        8'h01:   m_p <= m_m;
        8'h09:   m_p <= m_p + m_m;
        8'h08:   m_p <= m_p;
        default: m_p <= '0;
      endcase
    end
  end
  assign dsp_P = m_p;

  int n_first = 0;
  int n_acc   = 0;
  int n_hold  = 0;
  always @(negedge clk) begin
    if (dsp_opmode === 8'h01) n_first++;
    if (dsp_opmode === 8'h09) n_acc++;
    if (dsp_opmode === 8'h08) n_hold++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] va [4];
  logic [17:0] vb [4];

  task automatic run_job(input int n, input int gap, output int lat);
    start = 1'b1;
    len   = 8'(n);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_a     = va[i];
      in_b     = vb[i];
      tick();
      in_valid = 1'b0;
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) tick();
      end
    end
    chk("dsp_B_last_beat", dsp_B, vb[n-1]);
    chk("in_ready_drain", in_ready, 0);
    lat = 0;
    while (!res_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_job();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("busy_after_ack", busy, 0);
    chk("res_valid_after_ack", res_valid, 0);
    repeat (OPM_SKEW + 2) tick();
  endtask

  initial begin
    int lat;
    int f0, a0, h0;
    logic signed [17:0] sx;
    logic signed [47:0] pe;
    logic [47:0] exp_sq;

    RST = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_dsp_A", dsp_A, 0);
    chk("rst_dsp_B", dsp_B, 0);
    chk("rst_dsp_opmode", dsp_opmode, 8'h00);
    chk("rst_dsp_CE", dsp_CE, 0);
    chk("rst_dsp_RST", dsp_RST, 1);
    RST = 1'b0;
    tick();
    chk("run_dsp_CE", dsp_CE, 1);
    chk("run_dsp_RST", dsp_RST, 0);
    tick();

    // Back-to-back dot product: 200 + 30 + 12 = 242.
    va[0] = 18'd20; vb[0] = 18'd10;
    va[1] = 18'd5;  vb[1] = 18'd6;
    va[2] = 18'd3;  vb[2] = 18'd4;
    f0 = n_first; a0 = n_acc; h0 = n_hold;
    run_job(3, 0, lat);
    chk("b2b_latency", 64'(lat), 64'(PIPE_LAT + 1));
    chk("b2b_res_data", res_data, 48'hF2);
    chk("b2b_busy_done", busy, 1);
    finish_job();
    chk("b2b_opm_first", 64'(n_first - f0), 1);
    chk("b2b_opm_acc", 64'(n_acc - a0), 2);
    chk("b2b_opm_hold", 64'(n_hold - h0), 64'(PIPE_LAT + 1));

    // Two idle cycles between beats add four hold opmodes.
    f0 = n_first; a0 = n_acc; h0 = n_hold;
    run_job(3, 2, lat);
    chk("gap_latency", 64'(lat), 64'(PIPE_LAT + 1));
    chk("gap_res_data", res_data, 48'hF2);
    finish_job();
    chk("gap_opm_first", 64'(n_first - f0), 1);
    chk("gap_opm_acc", 64'(n_acc - a0), 2);
    chk("gap_opm_hold", 64'(n_hold - h0), 64'(4 + PIPE_LAT + 1));

    // Empty job.
    f0 = n_first; a0 = n_acc; h0 = n_hold;
    start = 1'b1; len = 8'd0;
    tick();
    start = 1'b0;
    chk("len0_res_valid", res_valid, 1);
    chk("len0_res_data", res_data, 0);
    chk("len0_busy", busy, 1);
    chk("len0_opmode", dsp_opmode, 8'h00);
    finish_job();
    chk("len0_opm_active", 64'((n_first - f0) + (n_acc - a0) + (n_hold - h0)), 0);

    // Result held under backpressure; a start during DONE is ignored.
    va[0] = 18'd20; vb[0] = 18'd10;
    va[1] = 18'd5;  vb[1] = 18'd6;
    va[2] = 18'd3;  vb[2] = 18'd4;
    run_job(3, 0, lat);
    chk("bp_latency", 64'(lat), 64'(PIPE_LAT + 1));
    for (int k = 0; k < 5; k++) begin
      start = (k == 1);
      len   = 8'd1;
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, 48'hF2);
      chk("bp_busy", busy, 1);
      tick();
    end
    start = 1'b0;
    finish_job();
    chk("bp_in_ready_idle", in_ready, 0);

    // Abort during LOAD, then a fresh single-pair job.
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_a = 18'd100; in_b = 18'd100;
    tick();
    in_valid = 1'b0;
    RST = 1'b1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_res_data", res_data, 0);
    chk("abort_dsp_RST", dsp_RST, 1);
    chk("abort_dsp_CE", dsp_CE, 0);
    RST = 1'b0;
    tick();
    chk("abort_dsp_CE_release", dsp_CE, 1);
    va[0] = 18'd7; vb[0] = 18'd9;
    run_job(1, 0, lat);
    chk("abort_latency", 64'(lat), 64'(PIPE_LAT + 1));
    chk("abort_res_data_new", res_data, 48'h3F);
    finish_job();

    // Full-scale operands: signed -1 * -1, summed twice, modulo 2^48.
    va[0] = 18'h3FFFF; vb[0] = 18'h3FFFF;
    va[1] = 18'h3FFFF; vb[1] = 18'h3FFFF;
    sx = 18'h3FFFF;
    pe = 48'(sx) * 48'(sx);
    exp_sq = pe + pe;
    run_job(2, 0, lat);
    chk("max_latency", 64'(lat), 64'(PIPE_LAT + 1));
    chk("max_res_data", res_data, exp_sq);
    finish_job();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 Parameter PIPE_LAT, default 4: cycles from dsp_A/dsp_B presentation to the matching result on dsp_P (A0, A1, M and P registers).
REQ-002 Parameter OPM_SKEW, default 2: cycles dsp_opmode lags its operands, compensating for the opmode register.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  job request, sampled in IDLE only.
REQ-006 len  in  8  number of operand pairs in the job, sampled with start.
REQ-007 busy  out  1  high from accepted start until the result handshake completes.
REQ-008 in_valid / in_ready  in / out  1 / 1  operand stream handshake.
REQ-009 in_a, in_b  in  18 / 18  operand pair.
REQ-010 dsp_A, dsp_B  out  18 / 18  registered operands to the DSP slice.
REQ-011 dsp_opmode  out  8  registered opmode to the DSP slice.
REQ-012 dsp_CE  out  1  drives all DSP clock enables.
REQ-013 dsp_RST  out  1  drives all DSP RSTx inputs.
REQ-014 dsp_P  in  48  DSP P output.
REQ-015 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-016 res_data  out  48  accumulated dot product.

Function
REQ-017 The block SHALL have states IDLE, LOAD, DRAIN and DONE.
REQ-018 IDLE: start=1 with len>0 SHALL go to LOAD; start=1 with len=0 SHALL go to DONE with res_data=0.
REQ-019 LOAD: in_ready=1; a beat is accepted when in_valid&in_ready; after len accepted beats, in_ready SHALL drop the next cycle and the state SHALL go to DRAIN.
REQ-020 A beat accepted at cycle t SHALL appear on dsp_A/dsp_B at t+1; its opmode SHALL appear at t+1+OPM_SKEW.
REQ-021 Opmode encoding: first accepted beat 8'h01 (P=M); later beats 8'h09 (P=P+M); cycles without an accepted beat 8'h08 before the first beat was accepted 8'h00; pre-adder, carry-in and post-subtract are never used.
REQ-022 DRAIN SHALL last exactly PIPE_LAT cycles measured from the last beat on dsp_A/dsp_B; at its end dsp_P SHALL be captured into res_data and the state SHALL go to DONE.
REQ-023 DONE: res_valid=1 and res_data held stable until res_ready=1; then IDLE, busy=0.
REQ-024 start while busy SHALL be ignored; in_valid outside LOAD SHALL be ignored (in_ready=0).
REQ-025 dsp_CE SHALL be 1 whenever RST=0; dsp_RST SHALL equal RST, registered.
REQ-026 Accumulation is modulo 2^48; no overflow flag.

Reset
REQ-027 When RST=1 at a clock edge, the state SHALL go to IDLE regardless of the current state; the job in progress is aborted.
REQ-028 Reset values: busy=0, in_ready=0, res_valid=0, res_data=0, dsp_A=0, dsp_B=0, dsp_opmode=8'h00, dsp_CE=0, dsp_RST=1.

Structure
REQ-029 Package dsp_seq_pkg SHALL hold the state enum and the opmode constants OPM_FIRST=8'h01, OPM_ACC=8'h09, OPM_HOLD=8'h08, OPM_ZERO=8'h00.
REQ-030 One sub-module, dsp_opmode_skew, SHALL implement the OPM_SKEW-deep opmode delay line; its reset value is OPM_ZERO.

Verification (bench: team DSP, all registers =1, B_INPUT="DIRECT", RSTTYPE="SYNC")
REQ-031 len=3, pairs (20,10),(5,6),(3,4) back-to-back -> res_data=48'hF2, res_valid exactly PIPE_LAT+1 cycles after the last dsp_B update.
REQ-032 Same job with in_valid low for 2 cycles between each beat -> res_data=48'hF2, bubble opmodes 8'h08.
REQ-033 start with len=0 -> DONE on the next cycle, res_data=0, dsp_opmode stays 8'h00.
REQ-034 res_ready held low 5 cycles -> res_valid and res_data=48'hF2 stable, busy=1, and a second start is ignored.
REQ-035 RST pulsed during LOAD after 1 beat, then a job with len=1 and pair (7,9) -> res_data=48'h3F, no residue from the aborted job.
REQ-036 len=2, pairs (18'h3FFFF,18'h3FFFF) twice -> res_data equals 2x the DSP product modulo 2^48, checked against the reference model.
